// File: rtl/cayde_ctrl_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/WRITEBACK sequencing with fetch timeout and sticky trap.
// Optional retired-instruction counter enabled by defining CAYDE_CTRL_PERFCNT_EN.
module cayde_ctrl_fsm #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        imem_ack,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        wb_stall,
  output logic        imem_req,
  output logic        ir_load,
  output logic        alu_en,
  output logic        reg_write,
  output logic        pc_en,
  output logic        trap,
`ifdef CAYDE_CTRL_PERFCNT_EN
  output logic [31:0] retired_cnt,
`endif
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd7
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(FETCH_TIMEOUT);
  localparam logic [6:0] OP_RTYPE    = 7'b0110011;
  localparam logic [6:0] OP_ITYPE    = 7'b0010011;
  localparam logic [6:0] F7_ZERO     = 7'b0000000;
  localparam logic [6:0] F7_ALT      = 7'b0100000;

  state_e     state_q, state_d;
  logic [7:0] fetch_cnt_q, fetch_cnt_d;
  logic       legal;

  always_comb begin
    legal = 1'b0;
    if (opcode == OP_RTYPE) begin
      legal = (funct7 == F7_ZERO) ||
              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else if (opcode == OP_ITYPE) begin
      case (funct3)
        3'b001:  legal = (funct7 == F7_ZERO);
        3'b101:  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
        default: legal = 1'b1;
      endcase
    end
  end

  // The fetch counter holds the no-ack cycles already spent; it reads 0 in every other state.
  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = 8'd0;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    alu_en      = 1'b0;
    reg_write   = 1'b0;
    pc_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 8'd1;
          if (fetch_cnt_d == TIMEOUT_CNT) state_d = TRAP;
        end
      end
      DECODE: begin
        state_d = legal ? EXECUTE : TRAP;
      end
      EXECUTE: begin
        alu_en  = 1'b1;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        if (!wb_stall) begin
          reg_write = 1'b1;
          pc_en     = 1'b1;
          state_d   = run ? FETCH : IDLE;
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
  end

`ifdef CAYDE_CTRL_PERFCNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q + {31'd0, reg_write};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_cnt_q <= 8'd0;
      retired_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      retired_q   <= retired_d;
    end
  end

  assign retired_cnt = retired_q;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end
`endif

  assign trap  = (state_q == TRAP);
  assign state = state_q;

endmodule

// File: doc/cayde_ctrl_fsm.md
CAYDE_CTRL_FSM -- requirements
Module: cayde_ctrl_fsm

Interface
REQ-001 Parameter FETCH_TIMEOUT, default 15, is the maximum number of cycles spent in FETCH without imem_ack before a trap; legal range is 1..255.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port run, input, 1 bit: enables the core to start or continue sequencing instructions.
REQ-005 Port imem_ack, input, 1 bit: instruction memory has valid instr this cycle.
REQ-006 Port opcode, input, 7 bits: instr[6:0] from the fetched instruction.
REQ-007 Port funct3, input, 3 bits: instr[14:12].
REQ-008 Port funct7, input, 7 bits: instr[31:25].
REQ-009 Port wb_stall, input, 1 bit: the register-file write port is busy; hold in WRITEBACK.
REQ-010 Port imem_req, output, 1 bit: fetch request.
REQ-011 Port ir_load, output, 1 bit: latch the instruction register.
REQ-012 Port alu_en, output, 1 bit: the ALU result is valid to capture.
REQ-013 Port reg_write, output, 1 bit: register-file write enable (drives RegWrite).
REQ-014 Port pc_en, output, 1 bit: PC register loads PC+4.
REQ-015 Port trap, output, 1 bit: sticky fault flag.
REQ-016 Port state, output, 3 bits: current state encoding.
REQ-017 Port retired_cnt, output, 32 bits, present only with CAYDE_CTRL_PERFCNT_EN: count of retired instructions.

Function
REQ-018 States SHALL be encoded as IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, TRAP=7; encodings 5 and 6 SHALL go to TRAP on the next edge.
REQ-019 IDLE: all strobes are 0; the next state is FETCH if run=1, otherwise IDLE.
REQ-020 FETCH: imem_req=1 for the whole state; on imem_ack=1, ir_load=1 in the same cycle (combinational) and the next state is DECODE.
REQ-021 FETCH timeout: an 8-bit counter clears on entering FETCH and increments each FETCH cycle without ack; when it reaches FETCH_TIMEOUT with imem_ack=0, the next state is TRAP.
REQ-022 If imem_ack=1 arrives in the same cycle the counter equals FETCH_TIMEOUT, the ack wins and the next state is DECODE.
REQ-023 DECODE (1 cycle): legal instructions go to EXECUTE; all others go to TRAP.
REQ-024 A legal instruction is either opcode 0110011 (R-type) or opcode 0010011 (I-type ALU).
REQ-025 R-type funct7 is legal when it is 0000000, or when it is 0100000 with funct3 000 or 101.
REQ-026 I-type funct7 is checked only for funct3 001 (must be 0000000) and funct3 101 (must be 0000000 or 0100000).
REQ-027 EXECUTE (1 cycle): alu_en=1; the next state is WRITEBACK.
REQ-028 WRITEBACK: while wb_stall=1, hold with all strobes 0.
REQ-029 WRITEBACK with wb_stall=0: reg_write=1 and pc_en=1 for exactly that cycle; the next state is FETCH if run=1, else IDLE.
REQ-030 TRAP: trap=1 and all strobes are 0; the state is held until reset; run has no effect.
REQ-031 Dropping run mid-instruction SHALL NOT abort it; it is sampled only in IDLE and at WRITEBACK exit.
REQ-032 Minimum instruction latency is 4 cycles (FETCH with immediate ack, DECODE, EXECUTE, WRITEBACK).
REQ-033 reg_write and pc_en SHALL never be asserted outside WRITEBACK, and each is asserted at most once per instruction.

Reset
REQ-034 rst=0 SHALL asynchronously force state=IDLE, the timeout counter to 0, trap=0, all strobes to 0, and retired_cnt to 0, including mid-FETCH or mid-WRITEBACK stall.
REQ-035 After rst deasserts, the first transition occurs on the next rising clk edge.

Configuration
REQ-036 With CAYDE_CTRL_PERFCNT_EN defined, retired_cnt increments by 1 on every WRITEBACK cycle with wb_stall=0 and wraps from 0xFFFFFFFF to 0.
REQ-037 Without CAYDE_CTRL_PERFCNT_EN, the retired_cnt port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-038 Scenario: run=1, imem_ack=1 on the first FETCH cycle, opcode=0110011, funct7=0, funct3=0 -> state sequence 1,2,3,4,1; reg_write=1 for exactly 1 cycle; retired_cnt=1.
REQ-039 Scenario: imem_ack held at 0 for 15 FETCH cycles with default parameter -> state=7 and trap=1 on the following edge; a second run with ack on the 15th cycle -> DECODE, no trap.
REQ-040 Scenario: opcode=0110011, funct7=0100000, funct3=001 -> TRAP after DECODE; reg_write never asserted.
REQ-041 Scenario: wb_stall=1 for 3 cycles in WRITEBACK -> state=4 held for 4 cycles; reg_write and pc_en both high only in the 4th cycle.
REQ-042 Scenario: rst pulsed low mid-stall -> outputs immediately 0, state=0; retired_cnt preset near 0xFFFFFFFF via a forced 0xFFFFFFFF + 1 retire -> 0.
REQ-043 Scenario: run dropped during EXECUTE -> the instruction completes, then state=0.
